// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for the free-running count value: a frame is sent on each
// count change or host request, with one pending slot and a sticky overrun flag.
module count_uart_tx #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] count_in,
   input  logic       send_req,
   output logic       tx,
   output logic       busy,
   output logic       overrun
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg, state_next;
   logic          tx_reg, tx_next;
   logic [7:0]    prev_count_reg;
   logic          pend_valid_reg, pend_valid_next;
   logic [7:0]    pend_data_reg, pend_data_next;
   logic [7:0]    shreg_reg, shreg_next;
   logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]    bit_idx_reg, bit_idx_next;
   logic          overrun_reg, overrun_next;

   logic trigger;
   logic baud_last;
   logic frame_end;

   assign trigger   = ena & ((count_in != prev_count_reg) | send_req);
   assign baud_last = (baud_cnt_reg == BAUD_LAST);
   assign frame_end = (state_reg == STOP) && baud_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         tx_reg         <= 1'b1;
         prev_count_reg <= 8'h00;
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= 8'h00;
         shreg_reg      <= 8'h00;
         baud_cnt_reg   <= '0;
         bit_idx_reg    <= 3'd0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         tx_reg         <= tx_next;
         prev_count_reg <= count_in;
         pend_valid_reg <= pend_valid_next;
         pend_data_reg  <= pend_data_next;
         shreg_reg      <= shreg_next;
         baud_cnt_reg   <= baud_cnt_next;
         bit_idx_reg    <= bit_idx_next;
         overrun_reg    <= overrun_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      tx_next         = tx_reg;
      shreg_next      = shreg_reg;
      bit_idx_next    = bit_idx_reg;
      pend_valid_next = pend_valid_reg;
      pend_data_next  = pend_data_reg;
      overrun_next    = overrun_reg;
      baud_cnt_next   = (state_reg == IDLE || baud_last) ? '0 : baud_cnt_reg + 1'b1;

      case (state_reg)
         IDLE: begin
            if (trigger) begin
               shreg_next = count_in;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (baud_last) begin
               tx_next      = shreg_reg[0];
               shreg_next   = {1'b0, shreg_reg[7:1]};
               bit_idx_next = 3'd0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               if (bit_idx_reg == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  tx_next      = shreg_reg[0];
                  shreg_next   = {1'b0, shreg_reg[7:1]};
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_last) begin
               if (pend_valid_reg) begin
                  shreg_next      = pend_data_reg;
                  pend_valid_next = 1'b0;
                  tx_next         = 1'b0;
                  state_next      = START;
               end else if (trigger) begin
                  // A trigger landing on an empty-slot stop end starts the next frame directly.
                  shreg_next = count_in;
                  tx_next    = 1'b0;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Capture into the pending slot; overrides the consume above when both happen.
      if (trigger && state_reg != IDLE && !(frame_end && !pend_valid_reg)) begin
         pend_data_next  = count_in;
         pend_valid_next = 1'b1;
         if (pend_valid_reg && !frame_end) begin
            overrun_next = 1'b1;
         end
      end
   end

   assign tx      = tx_reg;
   assign busy    = (state_reg != IDLE);
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: frame-position model checked every cycle,
// a line decoder collecting sent bytes, and hand-computed literal expectations.
module tb_count_uart_tx;

   localparam int D     = 4;
   localparam int FRAME = 10 * D;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] count_in = 8'h00;
   logic       send_req = 1'b0;
   logic       tx;
   logic       busy;
   logic       overrun;

   int n_cmp = 0;
   int n_err = 0;

   count_uart_tx #(.CLK_DIV(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .count_in (count_in),
      .send_req (send_req),
      .tx       (tx),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a frame is a position counter 0..FRAME-1 over one byte, plus one pending slot.
   logic       m_active = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_pv = 1'b0;
   logic [7:0] m_pd = 8'h00;
   logic       m_ovr = 1'b0;
   logic [7:0] m_prev = 8'h00;

   always @(posedge clk or negedge rst_n) begin
      logic       trig, a, pv, ov;
      int         p;
      logic [7:0] b, pd;
      if (!rst_n) begin
         m_active <= 1'b0; m_pos <= 0; m_byte <= 8'h00;
         m_pv <= 1'b0; m_pd <= 8'h00; m_ovr <= 1'b0; m_prev <= 8'h00;
      end else begin
         trig = ena && ((count_in != m_prev) || send_req);
         a = m_active; p = m_pos; b = m_byte; pv = m_pv; pd = m_pd; ov = m_ovr;
         if (a) begin
            p = p + 1;
            if (p == FRAME) begin
               if (pv) begin
                  b = pd; p = 0; pv = trig;
                  if (trig) pd = count_in;
               end else if (trig) begin
                  b = count_in; p = 0;
               end else begin
                  a = 1'b0; p = 0;
               end
            end else if (trig) begin
               if (pv) ov = 1'b1;
               pv = 1'b1; pd = count_in;
            end
         end else if (trig) begin
            a = 1'b1; p = 0; b = count_in;
         end
         m_active <= a; m_pos <= p; m_byte <= b; m_pv <= pv; m_pd <= pd; m_ovr <= ov;
         m_prev <= count_in;
      end
   end

   function automatic logic exp_tx(input logic act, input int pos, input logic [7:0] byt);
      int bitn;
      if (!act) return 1'b1;
      bitn = pos / D;
      if (bitn == 0) return 1'b0;
      if (bitn >= 9) return 1'b1;
      return byt[bitn-1];
   endfunction

   always @(negedge clk) begin
      chk("model_tx", {31'd0, tx}, {31'd0, exp_tx(m_active, m_pos, m_byte)});
      chk("model_busy", {31'd0, busy}, {31'd0, m_active});
      chk("model_overrun", {31'd0, overrun}, {31'd0, m_ovr});
   end

   // Line decoder: samples mid-bit and queues every completed byte.
   logic [7:0] rx_q[$];
   logic       d_busy = 1'b0;
   int         d_cnt = 0;
   logic [7:0] d_byte = 8'h00;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_busy <= 1'b0; d_cnt <= 0; d_byte <= 8'h00;
      end else if (!d_busy) begin
         if (tx == 1'b0) begin
            d_busy <= 1'b1; d_cnt <= 1;
         end
      end else begin
         if ((d_cnt % D) == D/2 && d_cnt / D >= 1 && d_cnt / D <= 8)
            d_byte[d_cnt/D-1] <= tx;
         if (d_cnt == 9*D + D/2) begin
            chk("stop_bit", {31'd0, tx}, 32'd1);
            rx_q.push_back(d_byte);
            d_busy <= 1'b0;
         end
         d_cnt <= d_cnt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_rx(input string name, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input int n);
      logic [7:0] exp_bytes[3];
      exp_bytes[0] = e0; exp_bytes[1] = e1; exp_bytes[2] = e2;
      chk({name, "_count"}, rx_q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < rx_q.size()) chk({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_bytes[i]});
         else chk({name, "_byte"}, 32'hFFFF_FFFF, {24'd0, exp_bytes[i]});
      end
      $display("%s: %0d frame(s) received", name, rx_q.size());
      rx_q.delete();
   endtask

   initial begin
      logic [9:0] pat;
      int nb;

      // Reset state
      tick(2);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_overrun", {31'd0, overrun}, 32'd0);
      rst_n = 1'b1;
      tick(5);
      chk("release_no_frame", {31'd0, busy}, 32'd0);

      // Single change 0x00 -> 0x35: start, 1,0,1,0,1,1,0,0, stop
      pat = 10'b1_00110101_0;
      count_in = 8'h35;
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         chk("t1_tx_bit", {31'd0, tx}, {31'd0, pat[c/D]});
         if (c == FRAME - 1) chk("t1_busy_last", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      chk("t1_busy_drop", {31'd0, busy}, 32'd0);
      tick(3);
      chk_rx("t1", 8'h35, 8'h00, 8'h00, 1);
      chk("t1_overrun", {31'd0, overrun}, 32'd0);

      // send_req with count steady
      ena = 1'b0; count_in = 8'h5A; tick(2);
      ena = 1'b1; tick(2);
      send_req = 1'b1; tick(1);
      send_req = 1'b0; tick(55);
      chk_rx("t2", 8'h5A, 8'h00, 8'h00, 1);

      // Back-to-back 0x01 then 0x02 mid-frame
      count_in = 8'h01;
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) nb++;
         if (i == 10) count_in = 8'h02;
      end
      chk("t3_busy_cycles", nb, 80);
      chk("t3_overrun", {31'd0, overrun}, 32'd0);
      chk_rx("t3", 8'h01, 8'h02, 8'h00, 2);

      // Trigger exactly at stop end while a frame is pending
      count_in = 8'hA1; tick(10);
      count_in = 8'hA2; tick(30);
      count_in = 8'hA3; tick(130);
      chk("t3b_overrun", {31'd0, overrun}, 32'd0);
      chk_rx("t3b", 8'hA1, 8'hA2, 8'hA3, 3);

      // Overrun
      count_in = 8'h10; tick(5);
      count_in = 8'h11; tick(5);
      count_in = 8'h12; tick(100);
      chk("t4_busy_idle", {31'd0, busy}, 32'd0);
      chk("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
      chk_rx("t4", 8'h10, 8'h12, 8'h00, 2);

      // ena gating
      ena = 1'b0;
      for (int v = 0; v < 6; v++) begin
         count_in = 8'(v);
         @(negedge clk);
         chk("t5_tx_idle", {31'd0, tx}, 32'd1);
         chk("t5_busy", {31'd0, busy}, 32'd0);
      end
      ena = 1'b1; tick(10);
      chk("t5_no_frame", {31'd0, busy}, 32'd0);
      chk_rx("t5", 8'h00, 8'h00, 8'h00, 0);

      // Async reset mid-DATA with one frame pending
      count_in = 8'hFF; tick(10);
      count_in = 8'h07; tick(10);
      chk("t6_busy_before", {31'd0, busy}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_tx", {31'd0, tx}, 32'd1);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_overrun", {31'd0, overrun}, 32'd0);
      count_in = 8'h00;
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("t6_no_frame_after", {31'd0, busy}, 32'd0);
      chk_rx("t6a", 8'h00, 8'h00, 8'h00, 0);
      count_in = 8'h33; tick(45);
      chk_rx("t6b", 8'h33, 8'h00, 8'h00, 1);
      chk("t6_overrun", {31'd0, overrun}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
- Downstream consumer of the 8-bit free-running counter value (currentCount) in the tt_um_mrmola top.
- Serialises the count as 8N1 UART frames on one pin (top maps tx to uio_out[0], uio_oe[0]=1).
- Sends a frame whenever the count changes or on host request.
- Has one pending-frame slot with sticky overrun reporting.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit; legal range 2..65535; baud counter width $clog2(CLK_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  trigger qualifier; when 0, no new triggers are accepted. An in-flight frame still completes.
- count_in  input  8  counter value from the upstream counter.
- send_req  input  1  level request; each cycle it is high with ena=1 is a trigger.
- tx  output  1  UART line, idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).
- overrun  output  1  sticky flag; set when a pending frame is overwritten, cleared only by reset.

Behaviour:
- Reset values (async, immediate): tx=1, busy=0, overrun=0, state=IDLE, prev_count=0, pend_valid=0, pend_data=0, shreg=0, baud_cnt=0, bit_idx=0.
- prev_count <= count_in every cycle, independent of ena.
- trigger = ena & ((count_in != prev_count) | send_req).
- States: IDLE, START, DATA, STOP.
- IDLE:
  - On an edge with trigger=1: shreg<=count_in, state<=START, tx<=0, baud_cnt<=0.
  - tx falls on the same edge the trigger is sampled, so latency is 0 cycles after the edge.
  - pend_valid is always 0 in IDLE.
- Baud timing: each of START, DATA bits and STOP lasts exactly CLK_DIV cycles. baud_cnt counts 0..CLK_DIV-1; the bit advances when baud_cnt==CLK_DIV-1.
- START -> DATA:
  - tx<=shreg[0], bit_idx<=0.
  - DATA sends LSB first, shifting shreg right each bit.
  - After bit 7: tx<=1, state<=STOP.
- STOP end:
  - If pend_valid: shreg<=pend_data, pend_valid<=0, tx<=0, state<=START (back-to-back, no idle gap).
  - Else: state<=IDLE; tx stays 1.
- Frame length: 10*CLK_DIV cycles. busy is high from the trigger edge until the edge that enters IDLE.
- Trigger while state != IDLE:
  - pend_data<=count_in, pend_valid<=1.
  - If pend_valid was already 1 and is not being consumed this edge: overwrite the data and set overrun<=1.
- Simultaneous STOP-end with pend_valid=1 and a new trigger:
  - The old pending value goes to shreg.
  - The new value goes to pend_data with pend_valid=1.
  - overrun is not set.
- Trigger on the IDLE edge: the frame starts directly and the pending slot is unused.
- ena=0 blocks all triggers. The current frame and any pending frame still transmit; prev_count keeps tracking.
- Reset mid-frame: tx returns to 1 immediately, pending is discarded, and no partial bits are sent after release.
- After reset release with count_in==0: no trigger. A nonzero count_in on the first cycle after release triggers a frame.

Test Plan (CLK_DIV=4):
- Single change: count_in 0x00->0x35 at edge N with ena=1 -> tx=0 for 4 cycles from N, then bits 1,0,1,0,1,1,0,0 for 4 cycles each, then stop=1. busy drops at N+40; overrun=0.
- send_req: count_in held at 0x5A, send_req high for 1 cycle -> one 0x5A frame of 40 cycles; no second frame.
- Back-to-back: 0x01 in IDLE, then 0x02 mid-frame -> 0x01 frame followed immediately by 0x02 frame (start bit at stop end, no gap). busy stays high for 80 cycles; overrun=0.
- Overrun: 0x10 starts a frame; 0x11 then 0x12 arrive during it -> frames 0x10 and 0x12 only; overrun=1, and it stays 1 after idle.
- ena gating: ena=0 while count_in steps 0x00..0x05 -> tx stays 1, busy=0. Raise ena with count_in steady -> no frame.
- Async reset: assert rst_n=0 mid-DATA of a 0xFF frame with one frame pending -> tx=1, busy=0, overrun=0 before the next clk edge. After release no frame is sent until the next trigger.
